// File: rtl/mont_mul_ctrl.sv
// -----------------------------------------------------------------------------
// mont_mul_ctrl
//
// Purpose:
//   Sequencer for a 512-bit bit-serial Montgomery multiplication. It computes
//   result = in_a * in_b * 2^-512 mod in_m. The 514-bit arithmetic is done by
//   an external adder/subtractor with a start/done handshake. For each bit of
//   A, two adder operations are issued:
//     1) C = C + (A[i] ? B : 0)
//     2) C = (C + (C[0] ? M : 0)) >> 1      (halving done inside the adder)
//   After 512 iterations, a final trial subtraction C - M brings the value
//   into [0, M).
//
//   Both per-bit operations are always issued. When a term is skipped, a zero
//   operand is sent instead. As a result, latency does not depend on the data.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous, active-high reset
//   start        - request a multiplication (only sampled while idle)
//   in_a, in_b   - 512-bit operands, both < in_m, latched on accepted start
//   in_m         - 512-bit odd modulus, latched on accepted start
//   result       - 512-bit product, held from done until the next start
//   done         - one-cycle pulse, result valid
//   busy         - high whenever the controller is not idle
//   add_start    - one-cycle request to the external adder
//   add_subtract - adder subtract select
//   add_shift    - adder right-shift-by-1 select
//   add_in_a     - 514-bit adder operand A
//   add_in_b     - 514-bit adder operand B
//   add_result   - 515-bit adder output; bit 514 is carry/borrow-adjusted MSB
//   add_done     - adder completion pulse (any latency >= 1 cycle)
// -----------------------------------------------------------------------------
module mont_mul_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] in_a,
    input  logic [511:0] in_b,
    input  logic [511:0] in_m,
    output logic [511:0] result,
    output logic         done,
    output logic         busy,
    output logic         add_start,
    output logic         add_subtract,
    output logic         add_shift,
    output logic [513:0] add_in_a,
    output logic [513:0] add_in_b,
    input  logic [514:0] add_result,
    input  logic         add_done
);

    localparam int W  = 512;
    localparam int CW = W + 2;    // accumulator width; C stays below 2*M
    localparam int IW = 9;        // bit counter width, counts 0..511

    localparam logic [IW-1:0] LAST_BIT = 9'd511;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADD_B    = 3'd1;
    localparam logic [2:0] ST_WAIT_B   = 3'd2;
    localparam logic [2:0] ST_ADD_M    = 3'd3;
    localparam logic [2:0] ST_WAIT_M   = 3'd4;
    localparam logic [2:0] ST_SUB      = 3'd5;
    localparam logic [2:0] ST_WAIT_SUB = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    logic [2:0]    state_reg;
    logic [2:0]    state_next;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  m_reg;
    logic [CW-1:0] c_reg;
    logic [IW-1:0] i_reg;
    logic [W-1:0]  result_reg;

    // Current multiplier bit, and the gated operands for the two per-bit
    // additions. When the selecting bit is 0, the operand becomes all zeros,
    // so that an adder operation is still issued.
    logic          a_bit;
    logic [W-1:0]  b_gated;
    logic [W-1:0]  m_gated;

    assign a_bit = a_reg[i_reg];

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_gate
            assign b_gated[gi] = b_reg[gi] & a_bit;
            assign m_gated[gi] = m_reg[gi] & c_reg[0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic and adder request/operand decode.
    //
    // The operands are decoded from the current state and from registers
    // that only change when leaving a WAIT state. This keeps them stable
    // from add_start until the matching add_done. In IDLE and DONE every
    // adder-facing output is 0, so reset clears them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        add_start    = 1'b0;
        add_subtract = 1'b0;
        add_shift    = 1'b0;
        add_in_a     = '0;
        add_in_b     = '0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ADD_B;
                end
            end

            ST_ADD_B: begin
                add_start  = 1'b1;
                add_in_a   = c_reg;
                add_in_b   = {2'b00, b_gated};
                state_next = ST_WAIT_B;
            end

            ST_WAIT_B: begin
                add_in_a = c_reg;
                add_in_b = {2'b00, b_gated};
                if (add_done) begin
                    state_next = ST_ADD_M;
                end
            end

            ST_ADD_M: begin
                add_start  = 1'b1;
                add_shift  = 1'b1;
                add_in_a   = c_reg;
                add_in_b   = {2'b00, m_gated};
                state_next = ST_WAIT_M;
            end

            ST_WAIT_M: begin
                add_shift = 1'b1;
                add_in_a  = c_reg;
                add_in_b  = {2'b00, m_gated};
                if (add_done) begin
                    state_next = (i_reg == LAST_BIT) ? ST_SUB : ST_ADD_B;
                end
            end

            ST_SUB: begin
                add_start    = 1'b1;
                add_subtract = 1'b1;
                add_in_a     = c_reg;
                add_in_b     = {2'b00, m_reg};
                state_next   = ST_WAIT_SUB;
            end

            ST_WAIT_SUB: begin
                add_subtract = 1'b1;
                add_in_a     = c_reg;
                add_in_b     = {2'b00, m_reg};
                if (add_done) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            m_reg      <= '0;
            c_reg      <= '0;
            i_reg      <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        m_reg <= in_m;
                        c_reg <= '0;
                        i_reg <= '0;
                    end
                end

                ST_WAIT_B: begin
                    if (add_done) begin
                        c_reg <= add_result[CW-1:0];
                    end
                end

                ST_WAIT_M: begin
                    if (add_done) begin
                        // The adder has already halved the sum.
                        c_reg <= add_result[CW-1:0];
                        if (i_reg != LAST_BIT) begin
                            i_reg <= i_reg + 1'b1;
                        end
                    end
                end

                ST_WAIT_SUB: begin
                    if (add_done) begin
                        // A borrow means C < M: keep C as-is, otherwise take C - M.
                        result_reg <= add_result[CW] ? c_reg[W-1:0]
                                                     : add_result[W-1:0];
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign result = result_reg;
    assign done   = (state_reg == ST_DONE);
    assign busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mont_mul_ctrl.sv
module tb_mont_mul_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [511:0] in_a;
    logic [511:0] in_b;
    logic [511:0] in_m;
    logic [511:0] result;
    logic         done;
    logic         busy;
    logic         add_start;
    logic         add_subtract;
    logic         add_shift;
    logic [513:0] add_in_a;
    logic [513:0] add_in_b;
    logic [514:0] add_result;
    logic         add_done;

    mont_mul_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_m         (in_m),
        .result       (result),
        .done         (done),
        .busy         (busy),
        .add_start    (add_start),
        .add_subtract (add_subtract),
        .add_shift    (add_shift),
        .add_in_a     (add_in_a),
        .add_in_b     (add_in_b),
        .add_result   (add_result),
        .add_done     (add_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] res;
        int           start_cyc;
        int           lat;
    } exp_t;

    exp_t sb_q[$];

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int adder_lat  = 1;
    int done_seen  = 0;
    int add_pulses = 0;
    int stab_bad   = 0;
    int txn_id     = 0;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Golden model: Montgomery reduction via REDC, using the inverse of m
    // modulo 2^512 obtained by Newton iteration.
    function automatic logic [511:0] mont_ref(input logic [511:0] a,
                                              input logic [511:0] b,
                                              input logic [511:0] m);
        logic [1039:0] mask, mm, inv, two, ab, k, t;
        mask = (1040'd1 << 512) - 1040'd1;
        two  = 1040'd2;
        mm   = {528'd0, m};
        inv  = 1040'd1;
        for (int n = 0; n < 10; n++) begin
            inv = (inv * (two - mm * inv)) & mask;
        end
        ab = {528'd0, a} * {528'd0, b};
        k  = ((~ab + 1040'd1) * inv) & mask;
        t  = (ab + k * mm) >> 512;
        if (t >= mm) t = t - mm;
        return t[511:0];
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Cycle counter: value S is the index of the rising edge that samples start.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // External adder model with a configurable latency of adder_lat cycles.
    initial begin
        logic [513:0] cap_a, cap_b;
        logic         cap_sub, cap_sh;
        logic [514:0] r;
        add_done   = 1'b0;
        add_result = '0;
        forever begin
            @(negedge clk);
            if (add_start && !reset) begin
                cap_a   = add_in_a;
                cap_b   = add_in_b;
                cap_sub = add_subtract;
                cap_sh  = add_shift;
                if (cap_sub) begin
                    r = {1'b0, cap_a} - {1'b0, cap_b};
                end else begin
                    r = {1'b0, cap_a} + {1'b0, cap_b};
                    if (cap_sh) r = r >> 1;
                end
                for (int k = 1; k <= adder_lat; k++) begin
                    @(posedge clk);
                    if (k < adder_lat) begin
                        @(negedge clk);
                        if (!reset && (add_in_a !== cap_a || add_in_b !== cap_b ||
                                       add_subtract !== cap_sub || add_shift !== cap_sh))
                            stab_bad++;
                    end
                end
                #1;
                add_result = r;
                add_done   = 1'b1;
                @(negedge clk);
                if (!reset && (add_in_a !== cap_a || add_in_b !== cap_b ||
                               add_subtract !== cap_sub || add_shift !== cap_sh))
                    stab_bad++;
                @(posedge clk);
                #1;
                add_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (add_start) add_pulses++;
        if (done && !reset) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("latency", cyc - e.start_cyc + 1, e.lat);
                txn_id++;
                $display("txn %0d: result[31:0]=%08h latency=%0d", txn_id, result[31:0],
                         cyc - e.start_cyc + 1);
            end
        end
    end

    task automatic issue(input logic [511:0] a, input logic [511:0] b,
                         input logic [511:0] m, input bit expect_accept);
        exp_t e;
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        in_m  = m;
        start = 1'b1;
        if (expect_accept) begin
            e.res       = mont_ref(a, b, m);
            e.start_cyc = cyc + 1;
            e.lat       = 512 * 2 * (1 + adder_lat) + (1 + adder_lat) + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        if (expect_accept) chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_seen == d0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (done_seen == d0) chk("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic run(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m);
        int d0;
        logic [511:0] exp_r;
        exp_r = mont_ref(a, b, m);
        d0 = done_seen;
        add_pulses = 0;
        issue(a, b, m, 1'b1);
        wait_done(d0);
        repeat (3) @(negedge clk);
        chk("result_hold", result, exp_r);
        chk("busy_after_done", busy, 1'b0);
        chk("operands_stable", stab_bad, 0);
    endtask

    task automatic rand_run();
        logic [511:0] m, a, b;
        m = rnd512();
        m[0] = 1'b1;
        if ($urandom_range(0, 1) == 1) m[511] = 1'b1;
        a = rnd512() % m;
        b = rnd512() % m;
        run(a, b, m);
    endtask

    initial begin
        logic [511:0] a1, b1, m1, a2, b2, m2;
        int d0, n;

        reset = 1'b1;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;
        in_m  = '0;
        #1;
        chk("reset_result", result, 512'd0);
        chk("reset_busy_done", {busy, done, add_start}, 3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // a = 0: zero result, 1024 loop operations plus the final subtraction
        adder_lat = 1;
        run(512'd0, 512'd2, 512'd3);
        chk("add_start_pulses", add_pulses, 1025);

        // 2^-512 mod 3 == 1
        run(512'd1, 512'd1, 512'd3);

        for (int t = 0; t < 16; t++) rand_run();

        adder_lat = 3;
        for (int t = 0; t < 4; t++) rand_run();
        adder_lat = 1;

        // Second start pulse arrives mid-run and must be ignored
        m1 = rnd512(); m1[0] = 1'b1; a1 = rnd512() % m1; b1 = rnd512() % m1;
        m2 = rnd512(); m2[0] = 1'b1; a2 = rnd512() % m2; b2 = rnd512() % m2;
        repeat (9) @(negedge clk);
        d0 = done_seen;
        issue(a1, b1, m1, 1'b1);
        repeat (488) @(negedge clk);
        issue(a2, b2, m2, 1'b0);
        wait_done(d0);
        repeat (3) @(negedge clk);
        chk("double_start_result", result, mont_ref(a1, b1, m1));
        chk("double_start_single_done", done_seen - d0, 1);

        // Reset during WAIT_M at i = 200 (ADD_M of bit 200 is pulse number 402)
        add_pulses = 0;
        issue(rnd512() % 512'd1000003, 512'd5, 512'd1000003, 1'b1);
        n = 0;
        while (add_pulses < 402 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_i200", add_pulses, 402);
        @(posedge clk);
        @(negedge clk);
        chk("in_wait_m", {add_shift, add_start}, 2'b10);
        #2;
        reset = 1'b1;
        sb_q.delete();
        #1;
        chk("abort_result", result, 512'd0);
        chk("abort_flags", {done, busy, add_start, add_subtract, add_shift}, 5'b00000);
        chk("abort_operands", {add_in_a, add_in_b}, 1028'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run(512'd1, 512'd1, 512'd3);

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
